// File: rtl/div_seq_pkg.sv
// Shared types and constants for the EX-stage sequential divider.
package div_seq_pkg;

   // Register bus width aliases
   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 2 * RegBus;
   typedef logic [RegBus-1:0]       reg_bus_t;
   typedef logic [DoubleRegBus-1:0] dreg_bus_t;

   // ALU op codes that route an instruction to the divider
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   // Handshake levels
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   // Iteration counter width (holds 0..RegBus)
   localparam int CntW = 6;

   // Sequencer states
   typedef enum logic [1:0] {
      DIV_FREE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// upper partial remainder and shift the resulting quotient bit in at the LSB.
module div_step
   import div_seq_pkg::*;
#(
   parameter int WIDTH = RegBus
) (
   input  logic [2*WIDTH:0] work_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [2*WIDTH:0] next_work_o
);

   logic [WIDTH:0] diff;

   // Partial remainder stays below 2*divisor, so diff[WIDTH] is a true sign bit
   always_comb begin
      diff = work_i[2*WIDTH:WIDTH] - {1'b0, divisor_i};
      if (diff[WIDTH]) begin
         next_work_o = {work_i[2*WIDTH-1:0], 1'b0};
      end else begin
         next_work_o = {diff[WIDTH-1:0], work_i[WIDTH-1:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for EX: magnitude conversion, WIDTH
// restoring iterations, sign fix-up, and a pipeline stall request.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = RegBus
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               annul_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stallreq_o
);

   div_state_t          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH:0]    work_q, work_d, step_work;
   logic [WIDTH-1:0]    divisor_q, divisor_d;
   logic                neg_dvd_q, neg_dvd_d;
   logic                neg_dvs_q, neg_dvs_d;
   logic [2*WIDTH-1:0]  result_q, result_d;

   // Magnitude of a two's complement operand (0x80.. maps to itself as unsigned)
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   // Conditional two's complement negation used for the sign fix-up
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic c);
      return c ? -v : v;
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .work_i      (work_q),
      .divisor_i   (divisor_q),
      .next_work_o (step_work)
   );

   // State and datapath registers; reset aborts any operation immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= DIV_FREE;
         cnt_q     <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         neg_dvd_q <= 1'b0;
         neg_dvs_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         divisor_q <= divisor_d;
         neg_dvd_q <= neg_dvd_d;
         neg_dvs_q <= neg_dvs_d;
         result_q  <= result_d;
      end
   end

   // Next-state and datapath update; annul overrides everything else
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      divisor_d = divisor_q;
      neg_dvd_d = neg_dvd_q;
      neg_dvs_d = neg_dvs_q;
      result_d  = result_q;
      if (annul_i) begin
         state_d  = DIV_FREE;
         cnt_d    = '0;
         result_d = '0;
      end else begin
         unique case (state_q)
            DIV_FREE: begin
               if (start_i == DivStart) begin
                  neg_dvd_d = signed_i & opdata1_i[WIDTH-1];
                  neg_dvs_d = signed_i & opdata2_i[WIDTH-1];
                  divisor_d = mag(opdata2_i, signed_i);
                  cnt_d     = '0;
                  if (opdata2_i == '0) begin
                     state_d = DIV_ZERO;
                  end else begin
                     state_d = DIV_ON;
                     work_d  = {{WIDTH{1'b0}}, mag(opdata1_i, signed_i), 1'b0};
                  end
               end
            end
            DIV_ZERO: begin
               result_d = '0;
               state_d  = DIV_END;
            end
            DIV_ON: begin
               if (cnt_q == CntW'(WIDTH)) begin
                  result_d = {neg_if(work_q[2*WIDTH:WIDTH+1], neg_dvd_q),
                              neg_if(work_q[WIDTH-1:0], neg_dvd_q ^ neg_dvs_q)};
                  cnt_d    = '0;
                  state_d  = DIV_END;
               end else begin
                  work_d = step_work;
                  cnt_d  = cnt_q + CntW'(1);
               end
            end
            DIV_END: begin
               if (start_i == DivStop) begin
                  result_d = '0;
                  state_d  = DIV_FREE;
               end
            end
            default: state_d = DIV_FREE;
         endcase
      end
   end

   assign result_o   = result_q;
   assign ready_o    = (state_q == DIV_END) ? DivResultReady : DivResultNotReady;
   assign stallreq_o = (state_q == DIV_ZERO) || (state_q == DIV_ON) ||
                       ((state_q == DIV_FREE) && start_i && !annul_i);

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq with a queue-based result scoreboard.
module tb_div_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        annul;
   logic        sgn;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [63:0] result;
   logic        ready;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [63:0] res;
   } exp_t;
   exp_t exp_q[$];

   logic ready_prev = 1'b0;

   div_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst_n),
      .start_i    (start),
      .annul_i    (annul),
      .signed_i   (sgn),
      .opdata1_i  (op1),
      .opdata2_i  (op2),
      .result_o   (result),
      .ready_o    (ready),
      .stallreq_o (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: compare the result each time ready rises
   always @(negedge clk) begin
      if (rst_n && ready && !ready_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: got result %h with nothing expected", result);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, result, e.res);
         end
      end
      ready_prev <= ready;
   end

   // Issue one divide, push its expectation, and check latency/stall length
   task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input int exp_cyc, input bit hold);
      exp_t e;
      int   stall_cnt = 0;
      int   cyc = 0;
      bit   got = 0;
      e.name = name;
      e.res  = {er, eq};
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      sgn   = s;
      op1   = a;
      op2   = b;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (ready) begin
            got = 1;
            break;
         end
         if (stall) stall_cnt++;
         cyc++;
         @(negedge clk);
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: ready not seen within 100 cycles, required %0d", name, exp_cyc);
         void'(exp_q.pop_back());
         start = 1'b0;
         return;
      end
      check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
      check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_cyc));
      check({name, "_stall_in_end"}, 64'(stall), 64'd0);
      if (!hold) begin
         start = 1'b0;
         @(negedge clk);
         #1;
         check({name, "_ready_drop"}, 64'(ready), 64'd0);
         check({name, "_result_clear"}, result, 64'd0);
      end
   endtask

   initial begin
      int ready_seen;
      rst_n = 1'b0;
      start = 1'b0;
      annul = 1'b0;
      sgn   = 1'b0;
      op1   = '0;
      op2   = '0;
      #1;
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_result", result, 64'd0);
      check("reset_stall", 64'(stall), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_div("u_100_7",      32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34, 0);
      do_div("s_m7_2",       32'hFFFFFFF9,   32'h2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   34, 0);
      do_div("s_7_m2",       32'h7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'h1,          34, 0);
      do_div("s_m7_m2",      32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'h3,          32'hFFFFFFFF,   34, 0);
      do_div("u_fff9_2",     32'hFFFFFFF9,   32'h2,          1'b0, 32'h7FFFFFFC,   32'h1,          34, 0);
      do_div("u_1234_0",     32'h1234,       32'h0,          1'b0, 32'h0,          32'h0,          2,  0);
      do_div("s_m5_0",       32'hFFFFFFFB,   32'h0,          1'b1, 32'h0,          32'h0,          2,  0);
      do_div("u_max_1",      32'hFFFFFFFF,   32'h1,          1'b0, 32'hFFFFFFFF,   32'h0,          34, 0);
      do_div("u_max_max",    32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h1,          32'h0,          34, 0);
      do_div("s_ovf",        32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'h0,          34, 0);
      do_div("u_0_5",        32'h0,          32'h5,          1'b0, 32'h0,          32'h0,          34, 0);

      // Annul has priority over start in IDLE
      @(negedge clk);
      start = 1'b1; annul = 1'b1; sgn = 1'b0; op1 = 32'd50; op2 = 32'd5;
      #1;
      check("annul_prio_stall", 64'(stall), 64'd0);
      @(negedge clk);
      #1;
      check("annul_prio_ready", 64'(ready), 64'd0);
      start = 1'b0; annul = 1'b0;

      // Annul mid-operation at cnt == 10
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
      repeat (11) @(negedge clk);
      #1;
      annul = 1'b1;
      start = 1'b0;
      #1;
      check("annul_stall_before", 64'(stall), 64'd1);
      @(negedge clk);
      #1;
      check("annul_stall_after", 64'(stall), 64'd0);
      check("annul_ready_after", 64'(ready), 64'd0);
      annul = 1'b0;
      ready_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (ready || stall) ready_seen++;
      end
      check("annul_quiet", 64'(ready_seen), 64'd0);
      do_div("u_9_3_post_annul", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 0);

      // Asynchronous reset in the middle of DIV_ON
      @(negedge clk);
      start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
      repeat (15) @(negedge clk);
      #2;
      check("rst_on_stall_before", 64'(stall), 64'd1);
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_on_stall", 64'(stall), 64'd0);
      check("rst_on_ready", 64'(ready), 64'd0);
      check("rst_on_result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_div("u_1000_3_post_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 34, 0);

      // Asynchronous reset while holding a finished result in DIV_END
      do_div("u_100_7_hold", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 1);
      #2;
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_end_ready", 64'(ready), 64'd0);
      check("rst_end_result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_div("s_m100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 34, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the integer divide unit of the EX stage. It accepts a divide request from the ALU control path once the instruction has been decoded as DIV or DIVU. It then runs a 32-iteration restoring-division datapath under an FSM and asserts a stall request for the duration of the operation. It returns a {remainder, quotient} pair to EX for writeback into HI/LO.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  divide request from EX; held high by EX until `ready_o` is seen.
- annul_i  in  1  cancel the current or pending operation (pipeline flush).
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i`.
- opdata1_i  in  WIDTH  dividend; sampled with `start_i`.
- opdata2_i  in  WIDTH  divisor; sampled with `start_i`.
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; valid only while `ready_o` = 1.
- ready_o  out  1  result valid.
- stallreq_o  out  1  request to hold the pipeline stages up to and including EX.

## Operation
- FSM states: IDLE, DIV_ZERO, DIV_ON, DIV_END. Counter `cnt` is 6 bits, range 0..WIDTH.
- IDLE:
  - With `start_i` = 1 and `annul_i` = 0, latch `signed_i` and both operands.
  - In signed mode, convert each negative operand to its magnitude and store it.
  - Divisor == 0 goes to DIV_ZERO. Otherwise go to DIV_ON with `cnt` = 0 and the internal 2*WIDTH+1 working register = {WIDTH'0, |dividend|, 1'b0}.
- DIV_ON, each cycle:
  - Compute `diff` = work[2W:W] − {1'b0, divisor}, a WIDTH+1-bit subtract.
  - If `diff` is negative, shift `work` left by 1 with LSB 0.
  - Otherwise set `work` = {diff[W-1:0], work[W-1:0], 1'b1}.
  - Increment `cnt`.
- DIV_ON completion: when `cnt` == WIDTH, no iteration is performed and the FSM goes to DIV_END. The sign fix-up is applied while loading the result register:
  - Quotient = work[W-1:0], negated if signed and the operand signs differ.
  - Remainder = work[2W:W+1], negated if signed and the dividend was negative.
- DIV_ZERO: takes one cycle, loads result = 0, then goes to DIV_END.
- DIV_END: `ready_o` = 1. Stay in DIV_END while `start_i` = 1. Return to IDLE when `start_i` = 0; the result register is cleared on that edge.
- `annul_i` = 1 in any state returns the FSM to IDLE on the next edge. `ready_o` never asserts for an annulled operation. `annul_i` has priority over `start_i`.
- Overflow case 0x80000000 / −1 (signed): quotient = 0x80000000, remainder = 0. This is wrap-around behaviour, and no exception is raised.
- `stallreq_o` is combinational:
  - 1 in DIV_ZERO and in DIV_ON.
  - 1 in IDLE when `start_i` && !`annul_i`, so EX stalls in the request cycle.
  - 0 in DIV_END and in all other cases.
- Reset: state = IDLE, `cnt` = 0, working and result registers = 0, `ready_o` = 0, `result_o` = 0, `stallreq_o` = 0 (the latter given `start_i` = 0). Reset asserted mid-operation aborts immediately and asynchronously.

## Timing
- Edge E0 samples `start_i` and enters DIV_ON.
- Edges E1..E32 perform the 32 iterations.
- E33 enters DIV_END; `ready_o` is high from E33 until the edge after `start_i` drops.
- Divide by zero: E0 enters DIV_ZERO, E1 enters DIV_END, and `ready_o` is high after E1.
- `stallreq_o` is high from the E0 cycle through the cycle ending at E33 (34 cycles), or through the cycle ending at E1 for divide by zero.
- A new operation may start no earlier than one IDLE cycle after DIV_END, because `start_i` must drop to leave DIV_END.

## Structure
- Shared package / defines holds:
  - State encoding enum `div_state_t` (DIV_FREE/IDLE=2'b00, DIV_ZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11).
  - Constants `DivResultReady` / `DivResultNotReady`, `DivStart` / `DivStop`, and `RegBus`-width aliases alongside the existing ALU-op defines.
- Natural sub-module `div_step`: the combinational single iteration. Inputs are `work` and `divisor`; outputs are `next_work`. It can be verified standalone.
- Sign conversion and fix-up stay in `div_seq`.

## Test plan
- Unsigned 100 / 7: `ready_o` rises after E33 with `result_o` = {32'd2, 32'd14}, and `stallreq_o` is high for exactly 34 cycles.
- Signed −7 / 2 (0xFFFFFFF9, 0x2): quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. Signed 7 / −2 gives quotient 0xFFFFFFFD and remainder 0x1.
- Divide by zero with 0x1234 / 0: `ready_o` after E1, `result_o` = 0, `stallreq_o` high for 2 cycles.
- Boundaries, each producing a remainder of 0:
  - 0xFFFFFFFF / 1 unsigned gives quotient 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000.
  - 0 / 5 gives quotient 0.
- `annul_i` pulse at `cnt` = 10: FSM returns to IDLE next edge, `ready_o` stays 0, and `stallreq_o` drops. A following 9 / 3 request completes with {0, 3}.
- `rst` asserted asynchronously mid DIV_ON: all outputs are 0 immediately. After release, a fresh request completes correctly.
